// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the array multiplier stream, the MAC stage and the
// downstream consumer of group totals.
interface mac_accumulator_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
);
  logic [7:0]       in_p;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             clr;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_p, in_valid, in_last, clr, out_ready,
    input  in_ready, out_sum, out_count, out_ovf, out_valid
  );

  modport slave (
    input  in_p, in_valid, in_last, clr, out_ready,
    output in_ready, out_sum, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate stage: sums groups of 8-bit products (closed by
// in_last or MAX_TERMS) and hands each total downstream over valid/ready.
module mac_accumulator #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  mac_accumulator_if.slave  bus
);

  typedef enum logic {S_ACC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] acc_n;
  logic [CNT_W-1:0] cnt_n;
  logic             ovf_n;
  logic             group_end;

  // One spare bit catches the carry that signals saturation.
  assign sum_w     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.in_p};
  assign acc_n     = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  assign ovf_n     = ovf_q | sum_w[ACC_W];
  assign cnt_n     = cnt_q + 1'b1;
  assign group_end = bus.in_last || (cnt_n == CNT_W'(MAX_TERMS));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      S_ACC: begin
        if (bus.clr) begin
          // clr beats a simultaneous accept; the dropped product is not counted.
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (bus.in_valid) begin
          acc_d = acc_n;
          cnt_d = cnt_n;
          ovf_d = ovf_n;
          if (group_end) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_sum_d   = acc_n;
            out_count_d = cnt_n;
            out_ovf_d   = ovf_n;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_ACC;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Ready depends on state and reset only, never on in_valid.
  assign bus.in_ready  = (state_q == S_ACC) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential multiply-accumulate stage that sits directly downstream of the 4x4 combinational array multiplier.
- Consumes a stream of 8-bit products through a valid/ready handshake.
- Sums each group of products, delimited by in_last or a MAX_TERMS limit, into a saturating accumulator.
- Presents each group total to the next stage through a second valid/ready handshake.

Parameters:
ACC_W, 12, accumulator/result width in bits; legal range 8..32.
MAX_TERMS, 16, maximum products per group; forced group end at this count; legal range 1..255.
CNT_W, 8, width of out_count; must hold MAX_TERMS.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_p  input  8  product from array multiplier (unsigned 0..225)
in_valid  input  1  in_p/in_last valid this cycle
in_last  input  1  this product closes the current group
in_ready  output  1  block can accept a product this cycle
clr  input  1  synchronous discard of partial group
out_sum  output  ACC_W  group total (saturated)
out_count  output  CNT_W  number of products in the group
out_ovf  output  1  group total saturated (sticky within group)
out_valid  output  1  out_sum/out_count/out_ovf valid
out_ready  input  1  downstream accepts result

Behaviour:
- Reset (rst=1, any time, asynchronous):
  - State goes to ACC; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready=0 while rst is high; in_ready=1 from the first clock after release.
  - A group or result in flight is discarded.
- States: ACC (collecting products) and DONE (holding a result). There is no other state.
- in_ready = (state==ACC) && !rst. It is combinational from state only and does not depend on in_valid.
- Accept in ACC when in_valid && in_ready:
  - Compute sum_n = acc + in_p in ACC_W+1 bits.
  - If sum_n > 2^ACC_W-1: acc_n = 2^ACC_W-1 and ovf set. Otherwise acc_n = sum_n.
  - cnt_n = cnt+1.
  - Once acc is saturated, further products keep acc saturated and ovf stays 1.
- Group end: an accept with in_last=1, or an accept where cnt_n == MAX_TERMS.
  - Next cycle: state=DONE, out_valid=1, out_sum=acc_n, out_count=cnt_n, out_ovf=ovf_n.
  - Latency is 1 cycle from the final accept edge to out_valid high.
- Non-final accept: acc/cnt/ovf update and the state stays ACC.
- DONE:
  - Outputs are held stable while out_valid && !out_ready.
  - in_ready=0, so upstream stalls.
  - When out_valid && out_ready at a clock edge: out_valid=0, acc=0, cnt=0, ovf=0, state=ACC.
  - out_sum/out_count/out_ovf keep their last value (don't-care when out_valid=0).
  - in_ready rises the cycle after the handshake. There is no same-cycle bypass; the maximum rate is one group per (N+1) cycles.
- in_valid=0 in ACC: no state change. Gaps between products are allowed.
- clr=1 in ACC: acc, cnt and ovf go to 0 next edge. Any accept in the same cycle is dropped (clr wins) and does not count.
- clr=1 in DONE: ignored; a completed result is never discarded by clr.
- Zero-length group: impossible, since a group ends only on an accept.
- MAX_TERMS=1: every accept ends a group.
- in_last on the MAX_TERMS-th accept: a single group end, not two.
- out_ready is ignored while out_valid=0.

Test Plan:
1. Reset then group 15,225,50 (products of 3x5, 15x15, 10x5) with in_last on 50, out_ready=1 -> out_valid one cycle after third accept, out_sum=290, out_count=3, out_ovf=0; in_ready high the following cycle.
2. 17 consecutive products of 225, no in_last, MAX_TERMS=16, ACC_W=12 -> first group ends on 16th accept, out_sum=3600, out_count=16, out_ovf=0; 17th product accepted only after out handshake, starting a new group with acc=225.
3. ACC_W=8, products 200,100 (in_last) -> out_sum=255, out_ovf=1, out_count=2; next group 8 (in_last) -> out_sum=8, out_ovf=0.
4. Backpressure: complete group of 8, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_sum=8 stable all 5 cycles; out_ready=1 -> handshake, in_ready=1 next cycle, pending product then accepted.
5. Accept 50,50, then clr=1 together with in_valid=1, in_p=99 -> 99 dropped; then 15 with in_last -> out_sum=15, out_count=1.
6. Assert rst asynchronously mid-group (between edges, after 2 accepts) and again while in DONE with out_valid=1 -> outputs zero immediately without a clock edge, in_ready=0 during reset; after release a new group 1,2 (in_last) -> out_sum=3, out_count=2.
